// File: rtl/llmint_scatter_stream_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : llmint_scatter_stream_if
// Brief    : Stream bundle between an activation source, the outlier-scatter
//            stage and the mixed-precision linear core.
// Revision : 1.0
// ============================================================================
interface llmint_scatter_stream_if #(
    parameter int PRECISION       = 16,
    parameter int TENSOR_SIZE_DIM = 4,
    parameter int COUNT_WIDTH     = 16
);
    logic [PRECISION*TENSOR_SIZE_DIM-1:0] data_in;
    logic                                 data_in_valid;
    logic                                 data_in_ready;
    logic [PRECISION*TENSOR_SIZE_DIM-1:0] data_out_high;
    logic [PRECISION*TENSOR_SIZE_DIM-1:0] data_out_low;
    logic                                 data_out_spill;
    logic                                 data_out_valid;
    logic                                 data_out_ready;
    logic [COUNT_WIDTH-1:0]               spill_count;

    // Source/sink side (drives activations, consumes split vectors)
    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out_high, data_out_low,
               data_out_spill, data_out_valid, spill_count
    );

    // Scatter stage side
    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out_high, data_out_low,
               data_out_spill, data_out_valid, spill_count
    );
endinterface
`default_nettype wire

// File: rtl/llmint_scatter_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : llmint_scatter_stream
// Brief    : Two-stage elastic outlier scatter: splits each activation vector
//            into high-precision and low-precision vectors, flags spills.
// Revision : 1.0
// ============================================================================
module llmint_scatter_stream #(
    parameter int PRECISION       = 16,
    parameter int TENSOR_SIZE_DIM = 4,
    parameter int HIGH_SLOTS      = 2,
    parameter int THRESHOLD       = 6,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    llmint_scatter_stream_if.slave bus
);
    localparam int c_VEC_W     = PRECISION * TENSOR_SIZE_DIM;
    localparam int c_CNT_W     = $clog2(TENSOR_SIZE_DIM + 1);
    localparam int c_SLOTS_INT = (HIGH_SLOTS > TENSOR_SIZE_DIM) ? TENSOR_SIZE_DIM : HIGH_SLOTS;
    localparam logic [c_CNT_W-1:0]   c_SLOTS = c_CNT_W'(c_SLOTS_INT);
    localparam logic [PRECISION:0]   c_THR   = (PRECISION + 1)'(THRESHOLD);

    // Stage 1 state
    logic                        r_s1_valid;
    logic [c_VEC_W-1:0]          r_s1_data;
    logic [TENSOR_SIZE_DIM-1:0]  r_s1_mask;

    // Stage 2 state
    logic                        r_s2_valid;
    logic [c_VEC_W-1:0]          r_s2_high;
    logic [c_VEC_W-1:0]          r_s2_low;
    logic                        r_s2_spill;
    logic [COUNT_WIDTH-1:0]      r_spill_count;

    logic                        w_s1_load;
    logic                        w_s2_load;
    logic                        w_out_fire;
    logic [TENSOR_SIZE_DIM-1:0]  w_mask;
    logic [c_VEC_W-1:0]          w_high;
    logic [c_VEC_W-1:0]          w_low;
    logic [c_CNT_W-1:0]          w_n_out;
    logic                        w_spill;

    assign w_s2_load  = !r_s2_valid || bus.data_out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign w_out_fire = r_s2_valid && bus.data_out_ready;

    // Magnitude is one bit wider so the most-negative code does not wrap.
    for (genvar gi = 0; gi < TENSOR_SIZE_DIM; gi++) begin : g_lane
        logic [PRECISION-1:0] w_elem;
        logic [PRECISION:0]   w_mag;
        assign w_elem     = bus.data_in[gi*PRECISION +: PRECISION];
        assign w_mag      = w_elem[PRECISION-1]
                          ? (~{w_elem[PRECISION-1], w_elem} + (PRECISION + 1)'(1))
                          : {1'b0, w_elem};
        assign w_mask[gi] = (w_mag > c_THR);
    end

    // Lowest-index outliers claim the high slots; the rest stay in the low vector.
    always_comb begin
        w_high  = '0;
        w_low   = '0;
        w_n_out = '0;
        for (int i = 0; i < TENSOR_SIZE_DIM; i++) begin
            if (r_s1_mask[i] && (w_n_out < c_SLOTS)) begin
                w_high[i*PRECISION +: PRECISION] = r_s1_data[i*PRECISION +: PRECISION];
            end else begin
                w_low[i*PRECISION +: PRECISION]  = r_s1_data[i*PRECISION +: PRECISION];
            end
            if (r_s1_mask[i]) begin
                w_n_out = w_n_out + c_CNT_W'(1);
            end
        end
    end

    assign w_spill = (w_n_out > c_SLOTS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_mask     <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_high     <= '0;
            r_s2_low      <= '0;
            r_s2_spill    <= 1'b0;
            r_spill_count <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= bus.data_in_valid;
                if (bus.data_in_valid) begin
                    r_s1_data <= bus.data_in;
                    r_s1_mask <= w_mask;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_high  <= w_high;
                    r_s2_low   <= w_low;
                    r_s2_spill <= w_spill;
                end
            end
            if (w_out_fire && r_s2_spill && (r_spill_count != {COUNT_WIDTH{1'b1}})) begin
                r_spill_count <= r_spill_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.data_in_ready  = w_s1_load;
    assign bus.data_out_valid = r_s2_valid;
    assign bus.data_out_high  = r_s2_high;
    assign bus.data_out_low   = r_s2_low;
    assign bus.data_out_spill = r_s2_spill;
    assign bus.spill_count    = r_spill_count;
endmodule
`default_nettype wire

// File: tb/tb_llmint_scatter_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_llmint_scatter_stream
// Brief    : Scoreboard bench for the outlier-scatter stage.
// Revision : 1.0
// ============================================================================
module tb_llmint_scatter_stream;
    localparam int c_P = 16;
    localparam int c_N = 4;

    typedef struct packed {
        logic [63:0] high;
        logic [63:0] low;
        logic        spill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   mode;
    exp_t q[$];
    int   occ;
    logic [15:0] exp_cnt;
    logic        held;
    logic [63:0] held_hi;
    logic [63:0] held_lo;
    logic        held_sp;
    int   n_out_b;
    logic [63:0] v_sat;

    llmint_scatter_stream_if #(.PRECISION(c_P), .TENSOR_SIZE_DIM(c_N), .COUNT_WIDTH(16)) bus_a ();
    llmint_scatter_stream_if #(.PRECISION(c_P), .TENSOR_SIZE_DIM(c_N), .COUNT_WIDTH(4))  bus_b ();

    llmint_scatter_stream #(
        .PRECISION(c_P), .TENSOR_SIZE_DIM(c_N), .HIGH_SLOTS(2), .THRESHOLD(6), .COUNT_WIDTH(16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    llmint_scatter_stream #(
        .PRECISION(c_P), .TENSOR_SIZE_DIM(c_N), .HIGH_SLOTS(0), .THRESHOLD(6), .COUNT_WIDTH(4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic exp_t model(input logic [63:0] v, input int hs);
        exp_t e;
        int   n;
        int   m;
        logic signed [15:0] x;
        e = '0;
        n = 0;
        for (int i = 0; i < c_N; i++) begin
            x = v[i*16 +: 16];
            m = (x < 0) ? -int'(x) : int'(x);
            if (m > 6) begin
                n++;
                if (n <= hs) e.high[i*16 +: 16] = x;
                else         e.low[i*16 +: 16]  = x;
            end else begin
                e.low[i*16 +: 16] = x;
            end
        end
        e.spill = (n > hs);
        return e;
    endfunction

    // Downstream ready: 0 = always, 1 = 1,0,0 pattern, 2 = stalled
    initial begin
        int ph;
        ph = 0;
        bus_a.data_out_ready = 1'b1;
        bus_b.data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       bus_a.data_out_ready = 1'b1;
                1: begin
                    bus_a.data_out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: bus_a.data_out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard / protocol monitor for DUT A, and output checker for DUT B
    initial begin
        logic out_hs;
        logic in_hs;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                occ     = 0;
                exp_cnt = '0;
                held    = 1'b0;
            end else begin
                check("in_ready", 64'(bus_a.data_in_ready), 64'(!(occ == 2 && !bus_a.data_out_ready)));
                check("spill_count", 64'(bus_a.spill_count), 64'(exp_cnt));
                if (held) begin
                    check("hold_valid", 64'(bus_a.data_out_valid), 64'(1));
                    check("hold_high", bus_a.data_out_high, held_hi);
                    check("hold_low", bus_a.data_out_low, held_lo);
                    check("hold_spill", 64'(bus_a.data_out_spill), 64'(held_sp));
                end
                out_hs = bus_a.data_out_valid && bus_a.data_out_ready;
                in_hs  = bus_a.data_in_valid && bus_a.data_in_ready;
                if (out_hs) begin
                    check("out_expected", 64'(q.size() > 0), 64'(1));
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("high", bus_a.data_out_high, e.high);
                        check("low", bus_a.data_out_low, e.low);
                        check("spill", 64'(bus_a.data_out_spill), 64'(e.spill));
                        if (e.spill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    end
                end
                held    = bus_a.data_out_valid && !bus_a.data_out_ready;
                held_hi = bus_a.data_out_high;
                held_lo = bus_a.data_out_low;
                held_sp = bus_a.data_out_spill;
                if (in_hs) q.push_back(model(bus_a.data_in, 2));
                occ = occ + int'(in_hs) - int'(out_hs);

                if (bus_b.data_out_valid && bus_b.data_out_ready) begin
                    n_out_b++;
                    check("b_high", bus_b.data_out_high, 64'(0));
                    check("b_low", bus_b.data_out_low, v_sat);
                    check("b_spill", 64'(bus_b.data_out_spill), 64'(1));
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] v);
        int   n;
        logic hs;
        n  = 0;
        bus_a.data_in       = v;
        bus_a.data_in_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = bus_a.data_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 50);
        if (!hs) check("send_timeout", 64'(hs), 64'(1));
    endtask

    // Presents one beat into an empty pipe and checks its 2-cycle latency.
    task automatic lat_test(input string tag, input logic [63:0] v,
                            input logic [63:0] eh, input logic [63:0] el, input logic es);
        bus_a.data_in       = v;
        bus_a.data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.data_in_valid = 1'b0;
        check({tag, "_valid_c1"}, 64'(bus_a.data_out_valid), 64'(0));
        @(posedge clk);
        #1;
        check({tag, "_valid_c2"}, 64'(bus_a.data_out_valid), 64'(1));
        check({tag, "_high"}, bus_a.data_out_high, eh);
        check({tag, "_low"}, bus_a.data_out_low, el);
        check({tag, "_spill"}, 64'(bus_a.data_out_spill), 64'(es));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || occ != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        mode    = 0;
        n_out_b = 0;
        occ     = 0;
        exp_cnt = '0;
        held    = 1'b0;
        v_sat   = pk(20, -30, 40, 3);
        rst     = 1'b1;
        bus_a.data_in       = '0;
        bus_a.data_in_valid = 1'b0;
        bus_b.data_in       = '0;
        bus_b.data_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus_a.data_out_valid), 64'(0));
        check("rst_high", bus_a.data_out_high, 64'(0));
        check("rst_low", bus_a.data_out_low, 64'(0));
        check("rst_spill", 64'(bus_a.data_out_spill), 64'(0));
        check("rst_count", 64'(bus_a.spill_count), 64'(0));
        rst = 1'b0;
        check("rst_ready", 64'(bus_a.data_in_ready), 64'(1));

        lat_test("t_basic", pk(1, 7, -9, 2), pk(0, 7, -9, 0), pk(1, 0, 0, 2), 1'b0);
        lat_test("t_spill", pk(20, -30, 40, 3), pk(20, -30, 0, 0), pk(0, 0, 40, 3), 1'b1);
        @(posedge clk);
        #1;
        check("t_spill_count", 64'(bus_a.spill_count), 64'(1));
        lat_test("t_bound", pk(6, -6, -32768, 0), pk(0, 0, -32768, 0), pk(6, -6, 0, 0), 1'b0);
        drain();

        // Back-to-back beats against a stalling sink
        mode = 1;
        for (int k = 0; k < 8; k++) begin
            int r0, r1, r2, r3;
            r0 = int'($urandom_range(0, 80)) - 40;
            r1 = int'($urandom_range(0, 80)) - 40;
            r2 = int'($urandom_range(0, 80)) - 40;
            r3 = int'($urandom_range(0, 80)) - 40;
            send_beat(pk(r0, r1, r2, r3));
        end
        bus_a.data_in_valid = 1'b0;
        drain();

        // Fill both stages, then reset with beats in flight
        mode = 2;
        @(posedge clk);
        #1;
        send_beat(pk(50, 51, 52, 53));
        send_beat(pk(-50, 1, 2, 3));
        bus_a.data_in_valid = 1'b0;
        @(negedge clk);
        check("full_stall_ready", 64'(bus_a.data_in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst  = 1'b1;
        mode = 0;
        #1;
        check("midrst_valid", 64'(bus_a.data_out_valid), 64'(0));
        check("midrst_count", 64'(bus_a.spill_count), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_test("t_post_rst", pk(100, -1, 2, -100), pk(100, 0, 0, -100), pk(0, -1, 2, 0), 1'b0);
        drain();

        // Saturating counter on the narrow-count, zero-slot instance
        bus_b.data_in       = v_sat;
        bus_b.data_in_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus_b.data_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("b_count_sat", 64'(bus_b.spill_count), 64'(15));
        check("b_beats", 64'(n_out_b), 64'(20));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/llmint_scatter_stream.md
Name: llmint_scatter_stream

Overview:
Registered, handshaked outlier-scatter stage that sits directly upstream of the LLMint mixed-precision linear core. It splits each input activation vector into a high-precision vector and a low-precision vector. The high vector carries the first HIGH_SLOTS elements whose magnitude exceeds THRESHOLD; the low vector carries every other element. The block replaces the combinational scatter with a 2-stage elastic pipeline and adds spill reporting for vectors that hold more outliers than slots.

Parameters:
PRECISION, 16, bit width of each signed element.
TENSOR_SIZE_DIM, 4, elements per vector.
HIGH_SLOTS, 2, maximum elements routed to the high vector per beat.
THRESHOLD, 6, unsigned magnitude threshold; an element is an outlier iff |x| > THRESHOLD.
COUNT_WIDTH, 16, width of the spill counter.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
data_in  in  PRECISION x TENSOR_SIZE_DIM  signed input vector.
data_in_valid  in  1  input beat valid.
data_in_ready  out  1  stage 1 can accept.
data_out_high  out  PRECISION x TENSOR_SIZE_DIM  outliers kept in position; all other lanes 0.
data_out_low  out  PRECISION x TENSOR_SIZE_DIM  non-selected elements kept in position; selected lanes 0.
data_out_spill  out  1  this beat had more than HIGH_SLOTS outliers.
data_out_valid  out  1  output beat valid.
data_out_ready  in  1  downstream accepts.
spill_count  out  COUNT_WIDTH  saturating count of spilled beats accepted downstream.

Behaviour:
- Reset (asynchronous, active-high): all valid flags, data registers, data_out_spill and spill_count go to 0. data_in_ready is 1 in the first cycle after reset deasserts.
- Pipeline:
  - S1 registers data_in and a per-lane outlier mask.
  - S2 registers the high vector, low vector and spill flag.
  - Latency is 2 cycles from input handshake to data_out_valid.
  - Throughput is 1 beat per cycle when data_out_ready is held high.
- Handshake:
  - Each stage loads when its valid is 0 or the next stage consumes this cycle.
  - s2_load = !s2_valid | data_out_ready.
  - s1_load = !s1_valid | s2_load.
  - data_in_ready = s1_load, combinational.
  - Data and valid hold stable while data_out_valid=1 and data_out_ready=0.
  - No beat is lost or duplicated under any ready/valid pattern.
- Magnitude: compute |x| at PRECISION+1 bits, so the most-negative value (-32768 at 16b) counts as 32768 and is an outlier. The compare is strict; |x| == THRESHOLD goes to low.
- Selection:
  - Scan lanes from index 0 upward.
  - The first HIGH_SLOTS outlier lanes are selected to the high vector.
  - Later outliers go to the low vector, unquantised and unchanged; quantisation happens downstream.
  - Every lane is nonzero in at most one output vector.
  - The element-wise sum of the high and low vectors equals data_in.
- Spill flag: data_out_spill = 1 iff the outlier count exceeds HIGH_SLOTS.
- spill_count:
  - Increments by 1 on each output handshake (data_out_valid & data_out_ready) where data_out_spill=1.
  - Saturates at all-ones and never wraps.
  - It does not increment while stalled.
- HIGH_SLOTS >= TENSOR_SIZE_DIM means no spill is ever possible and every outlier is selected. HIGH_SLOTS = 0 means the high vector is always 0.
- Reset asserted mid-stream clears both stages immediately. In-flight beats are discarded, and there is no output activity until new input arrives.
- Input handshake and output handshake in the same cycle with both stages full: both advance, and occupancy is unchanged.

Test Plan:
- Reset, then data_in=[1,7,-9,2] (lane 0 first), out_ready=1 -> 2 cycles later: high=[0,7,-9,0], low=[1,0,0,2], spill=0.
- Input [20,-30,40,3] with HIGH_SLOTS=2 -> high=[20,-30,0,0], low=[0,0,40,3], spill=1; spill_count goes 0 -> 1 on handshake.
- Boundary values [6,-6,-32768,0] -> high=[0,0,-32768,0], low=[6,-6,0,0], spill=0.
- Back-to-back 8 beats with data_out_ready toggling 1,0,0,1,... -> outputs match the reference model in order, none dropped or duplicated, data stable while stalled; data_in_ready drops only when both stages are full and downstream is stalled.
- Assert rst for 1 cycle while 2 beats are in flight -> data_out_valid=0 and spill_count=0 immediately; next input emerges after exactly 2 cycles.
- Force spill_count near saturation (COUNT_WIDTH=4), send 20 spilled beats -> count sticks at 15.
